// File: rtl/sub8.sv
// Registered WIDTH-bit subtractor in a + ~b + ci form, one operation per cycle,
// producing difference, carry-out (no-borrow), zero and signed-overflow flags.
module sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             zero,
  output logic             ovf
);

  function automatic logic [WIDTH:0] sub_with_carry(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             c
  );
    return {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Overflow only when operand signs differ and the result sign leaves the minuend's.
  function automatic logic signed_overflow(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] d
  );
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  logic [WIDTH:0]            sum_p0;
  logic signed [WIDTH-1:0]   diff_p0;
  logic                      zero_p0;
  logic                      ovf_p0;

  always_comb begin
    sum_p0  = sub_with_carry(a, b, ci);
    diff_p0 = sum_p0[WIDTH-1:0];
    zero_p0 = (diff_p0 == '0);
    ovf_p0  = signed_overflow(a, b, diff_p0);
  end

  // p0 -> p1: capture on in_valid, otherwise hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= diff_p0;
        co   <= sum_p0[WIDTH];
        zero <= zero_p0;
        ovf  <= ovf_p0;
      end
    end
  end

endmodule

// File: tb/tb_sub8.sv
// Directed-vector bench for sub8 with hand-computed expected results.
module tb_sub8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic       out_valid;
  logic [7:0] s;
  logic       co;
  logic       zero;
  logic       ovf;

  int checks;
  int failures;

  sub8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .ci       (ci),
    .out_valid(out_valid),
    .s        (s),
    .co       (co),
    .zero     (zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [7:0] es,
                            input logic ec, input logic ez, input logic eo);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".s"},         {24'b0, s},         {24'b0, es});
    chk({tag, ".co"},        {31'b0, co},        {31'b0, ec});
    chk({tag, ".zero"},      {31'b0, zero},      {31'b0, ez});
    chk({tag, ".ovf"},       {31'b0, ovf},       {31'b0, eo});
  endtask

  // Drive on the falling edge, let one rising edge capture, sample just after it.
  task automatic op(input logic v, input logic [7:0] ta, input logic [7:0] tb_, input logic tci);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    ci       = tci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h01;
    ci       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    expect_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    op(1'b1, 8'hFF, 8'h7F, 1'b1);
    expect_all("ff_7f", 1'b1, 8'h80, 1'b1, 1'b0, 1'b0);

    op(1'b1, 8'h1F, 8'h0F, 1'b1);
    expect_all("b2b_1", 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    op(1'b1, 8'h01, 8'h01, 1'b1);
    expect_all("b2b_2", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);

    op(1'b1, 8'h80, 8'h01, 1'b1);
    expect_all("ovf_80_01", 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);
    op(1'b1, 8'h10, 8'h01, 1'b1);
    expect_all("no_ovf_10_01", 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);

    op(1'b1, 8'h00, 8'h01, 1'b1);
    expect_all("borrow_00_01", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    op(1'b1, 8'h10, 8'h01, 1'b0);
    expect_all("ci0_10_01", 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);

    op(1'b0, 8'hxx, 8'hxx, 1'bx);
    expect_all("idle_x_1", 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0);
    op(1'b0, 8'hxx, 8'hxx, 1'bx);
    expect_all("idle_x_2", 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0);

    op(1'b1, 8'h33, 8'h11, 1'b1);
    expect_all("pre_reset", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);

    // Launch another op, then pull reset between edges before it matters.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h80;
    b        = 8'h01;
    ci       = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expect_all("async_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_all("held_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_all("post_release_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    op(1'b1, 8'h05, 8'h03, 1'b1);
    expect_all("after_reset", 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);

    op(1'b0, 8'h00, 8'h00, 1'b1);
    expect_all("final_hold", 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub8.md
SUB8 -- requirements
Module: sub8

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; all width references below use WIDTH=8 for concrete values.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  high = a, b, ci hold an operation to be captured this cycle.
REQ-005 Port: a  input  WIDTH  minuend, unsigned or two's-complement.
REQ-006 Port: b  input  WIDTH  subtrahend.
REQ-007 Port: ci  input  1  carry-in of the a + ~b + ci form; 1 = no borrow-in, 0 = borrow-in of one.
REQ-008 Port: out_valid  output  1  high = s, co, zero, ovf hold a fresh result.
REQ-009 Port: s  output  WIDTH  registered difference.
REQ-010 Port: co  output  1  registered carry-out; 1 = no borrow (a >= b + ~ci, unsigned), 0 = borrow.
REQ-011 Port: zero  output  1  registered flag; 1 when s is all zeros.
REQ-012 Port: ovf  output  1  registered signed-overflow flag.

Function
REQ-013 Arithmetic: {co, s} SHALL equal the (WIDTH+1)-bit sum a + (~b) + ci, with a and ~b zero-extended to WIDTH+1 bits.
REQ-014 With ci=1 the result SHALL be s = (a - b) mod 2^WIDTH; with ci=0 the result SHALL be s = (a - b - 1) mod 2^WIDTH.
REQ-015 ovf SHALL be 1 exactly when a[MSB] != b[MSB] and s[MSB] != a[MSB].
REQ-016 zero SHALL be computed from the same-cycle s value and registered alongside it.
REQ-017 Latency: a result for operands captured on rising edge N SHALL appear on s/co/zero/ovf with out_valid=1 after edge N and hold until the next capturing edge.
REQ-018 Throughput: one operation per cycle; back-to-back in_valid cycles SHALL each produce a result one cycle later, with no bubbles.
REQ-019 When in_valid=0 at an edge, out_valid SHALL go 0 and s, co, zero, ovf SHALL hold their previous values.
REQ-020 No input backpressure: every in_valid=1 cycle SHALL be accepted.
REQ-021 Wrap-around: results SHALL wrap modulo 2^WIDTH, with no saturation; underflow SHALL be signalled only through co=0.
REQ-022 Inputs containing X/Z SHALL only be applied with in_valid=0; the registered outputs in that case SHALL retain their prior values.

Reset
REQ-023 While rst_n=0, s SHALL be 0, co SHALL be 0, zero SHALL be 0, ovf SHALL be 0 and out_valid SHALL be 0, regardless of clk.
REQ-024 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-025 Reset SHALL abort any in-flight result.
REQ-026 The first capture after reset SHALL occur on the first rising edge at which rst_n=1 and in_valid=1.

Verification
REQ-027 The bench SHALL apply a=FF, b=7F, ci=1 -> next cycle: s=80, co=1, zero=0, ovf=0, out_valid=1.
REQ-028 The bench SHALL apply back-to-back a=1F, b=0F, ci=1 then a=01, b=01, ci=1 -> s=10, co=1, then s=00, co=1, zero=1 on consecutive cycles.
REQ-029 The bench SHALL apply a=80, b=01, ci=1 -> s=7F, co=1, ovf=1; a=10, b=01, ci=1 -> s=0F, co=1, ovf=0.
REQ-030 The bench SHALL apply a=00, b=01, ci=1 -> s=FF, co=0 (borrow); a=10, b=01, ci=0 -> s=0E, co=1.
REQ-031 The bench SHALL drive in_valid=0 with a, b, ci = X -> out_valid=0 and s/co/zero/ovf unchanged from the prior result.
REQ-032 The bench SHALL assert rst_n=0 mid-stream between clock edges -> all outputs 0 immediately; after release, a=05, b=03, ci=1 -> s=02, co=1.
